// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the SPI-configured PWM duty controller: bank geometry
// and the bit layout of the 8-bit configuration frame.
package pwm_cfg_pkg;

    localparam int NUM_CH  = 7;
    localparam int DUTY_W  = 3;
    localparam int FRAME_W = 8;
    localparam int ADDR_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_BROADCAST = 3'd7;

    // Frame layout, bit 7 shifted in first: addr | duty | commit | parity
    localparam int ADDR_MSB   = 7;
    localparam int ADDR_LSB   = 5;
    localparam int DUTY_MSB   = 4;
    localparam int DUTY_LSB   = 2;
    localparam int COMMIT_BIT = 1;
    localparam int PARITY_BIT = 0;

endpackage

// File: rtl/spi_frame_rx.sv
// Oversampling SPI mode-0 receiver: synchronises the pins, shifts bits on sck
// rising edges and reports each 8-bit frame as a good or bad registered pulse.
module spi_frame_rx
    import pwm_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spi_sck,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_bad
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_prev;
    logic                   sck_rise;
    logic [FRAME_W-2:0]     shift_q;   // the eighth bit comes straight from mosi_s
    logic [2:0]             bit_cnt;
    logic [FRAME_W-1:0]     frame_next;
    logic                   parity_ok;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev & ~cs_s;
    assign frame_next = {shift_q, mosi_s};
    assign parity_ok  = (^frame_next[FRAME_W-1:PARITY_BIT+1]) == frame_next[PARITY_BIT];

    // Reset values match the idle bus so no spurious edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of the one before it.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_prev    <= 1'b0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_bad   <= 1'b0;
            frame_data  <= '0;
        end else begin
            sck_prev    <= sck_s;
            frame_valid <= 1'b0;
            frame_bad   <= 1'b0;
            if (cs_s) begin
                // Counter is held at 0 while deselected, so a partial frame flags only once.
                bit_cnt <= '0;
                if (bit_cnt != 3'd0) frame_bad <= 1'b1;
            end else if (sck_rise) begin
                shift_q <= frame_next[FRAME_W-2:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    frame_data  <= frame_next;
                    frame_valid <= parity_ok;
                    frame_bad   <= ~parity_ok;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_spi_cfg_ctrl.sv
// Shadow/active duty banks for the PWM driver; SPI frames fill the shadow bank
// and a commit copies it into the active bank at the next period boundary.
module pwm_spi_cfg_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_sck,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    input  logic                     period_start,
    output logic [NUM_CH*DUTY_W-1:0] duty_active,
    output logic                     commit_pending,
    output logic                     updated,
    output logic                     frame_err
);

    logic               frame_valid;
    logic               frame_bad;
    logic [FRAME_W-1:0] frame_data;
    logic [ADDR_W-1:0]  frame_addr;
    logic [DUTY_W-1:0]  frame_duty;
    logic               frame_wr;
    logic [DUTY_W-1:0]  shadow [NUM_CH];

    spi_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_bad   (frame_bad)
    );

    assign frame_addr = frame_data[ADDR_MSB:ADDR_LSB];
    assign frame_duty = frame_data[DUTY_MSB:DUTY_LSB];
    assign frame_wr   = frame_valid & ~(^frame_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the shadow bank is a handful of flops that must read 0 after reset, so it is reset like any other register.
            for (int c = 0; c < NUM_CH; c++) shadow[c] <= '0;
            duty_active    <= '0;
            commit_pending <= 1'b0;
            updated        <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            updated   <= 1'b0;
            frame_err <= frame_bad;
            if (period_start && commit_pending) begin
                for (int c = 0; c < NUM_CH; c++) duty_active[c*DUTY_W +: DUTY_W] <= shadow[c];
                commit_pending <= 1'b0;
                updated        <= 1'b1;
            end
            // A frame landing with period_start is applied after the copy; a new commit wins over the clear.
            if (frame_wr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (frame_addr == ADDR_BROADCAST || frame_addr == ADDR_W'(c))
                        shadow[c] <= frame_duty;
                end
                if (frame_data[COMMIT_BIT]) commit_pending <= 1'b1;
            end
        end
    end

endmodule
